// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Holds the PC, issues sequential word fetches to a 1-cycle-latency
//   instruction memory, buffers the returned words in a small FIFO and hands
//   them to decode with a valid/ready handshake. A redirect flushes buffered
//   and in-flight fetches and restarts fetching at the new target.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   imem_req/imem_addr    fetch request and word-aligned address
//   imem_rdata            instruction word, valid 1 cycle after imem_req
//   redirect_valid/_pc    load a new PC and flush
//   ins/ins_pc/ins_valid  FIFO head to decode; ins_ready accepts it
//   ins_illegal           head opcode outside the supported set
//
// Optional feature: define IFETCH_OPCODE_CHECK_EN to enable the per-entry
// opcode check; otherwise ins_illegal is tied to 0.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ins,
   output logic [31:0] ins_pc,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic        ins_illegal
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_V = CW'(FIFO_DEPTH);

   logic [31:0]   pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] committed;
   logic          pop, push;
   logic [31:0]   fifo_ins [FIFO_DEPTH];
   logic [31:0]   fifo_pc  [FIFO_DEPTH];

   // Low address bits of the redirect target are discarded by design.
   logic unused_bits;
   assign unused_bits = ^redirect_pc[1:0];

   assign ins_valid = (count != '0);
   assign pop       = ins_valid & ins_ready;
   // A response returning during a redirect cycle is stale and dropped.
   assign push      = inflight & ~redirect_valid;

   // Slots already claimed (buffered + in flight) after this cycle's pop.
   // Gated by rst_n so the request drops the instant reset is asserted.
   assign committed = count + CW'(inflight) - CW'(pop);
   assign imem_req  = rst_n & ~redirect_valid & (committed < DEPTH_V);
   assign imem_addr = pc;

   assign ins    = ins_valid ? fifo_ins[rd_ptr] : 32'h0;
   assign ins_pc = ins_valid ? fifo_pc[rd_ptr]  : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'h0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) inflight_pc <= pc;
         if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (imem_req) pc <= pc + 32'd4;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

`ifdef IFETCH_OPCODE_CHECK_EN
   logic fifo_ill [FIFO_DEPTH];

   function automatic logic opcode_bad(input logic [6:0] op);
      return !(op == 7'b0000011 || op == 7'b0100011 ||
               op == 7'b0010011 || op == 7'b0110011);
   endfunction

   assign ins_illegal = ins_valid & fifo_ill[rd_ptr];
`else
   assign ins_illegal = 1'b0;
`endif

   // Storage needs no reset: entries are only observed when counted valid.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         fifo_ins[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]  <= inflight_pc;
`ifdef IFETCH_OPCODE_CHECK_EN
         fifo_ill[wr_ptr] <= opcode_bad(imem_rdata[6:0]);
`endif
      end
   end

   // Writing a full FIFO without a same-cycle pop would lose a word.
   assert property (@(posedge clk) disable iff (!rst_n)
                    !(push && (count == DEPTH_V) && !pop));

endmodule
